// File: rtl/key_event_generator.sv
// Turns debounced push-button levels into single-cycle press, auto-repeat and release
// events for one tracked key at a time.
module key_event_generator #(
  parameter int                  NUM_KEYS      = 4,
  parameter int                  REPEAT_DELAY  = 5000000,
  parameter int                  REPEAT_PERIOD = 1000000,
  parameter logic [NUM_KEYS-1:0] REPEAT_ENABLE = {NUM_KEYS{1'b1}},
  localparam int                 KEY_W         = $clog2(NUM_KEYS)
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [NUM_KEYS-1:0] i_Switch,
  output logic                o_Event_Valid,
  output logic [KEY_W-1:0]    o_Event_Key,
  output logic                o_Event_Repeat,
  output logic                o_Release_Pulse,
  output logic                o_Active
);

  // state       | meaning
  // IDLE        | no key tracked, waiting for any press
  // HOLD_DELAY  | key held, timing the initial repeat delay
  // HOLD_REPEAT | key held, issuing periodic repeats
  // HOLD_NOREP  | key held, auto-repeat disabled for this key
  // WAIT_ALL    | tracked key released, waiting for all keys up
  typedef enum logic [2:0] {
    IDLE,
    HOLD_DELAY,
    HOLD_REPEAT,
    HOLD_NOREP,
    WAIT_ALL
  } state_t;

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [KEY_W-1:0]  first_key;
  logic              key_held;

  // Lowest pressed index wins when several keys rise together.
  always_comb begin
    first_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (i_Switch[i]) first_key = KEY_W'(i);
    end
  end

  // o_Event_Key doubles as the latched key of the tracked press.
  assign key_held = i_Switch[o_Event_Key];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state           <= IDLE;
      cnt             <= '0;
      o_Event_Valid   <= 1'b0;
      o_Event_Key     <= '0;
      o_Event_Repeat  <= 1'b0;
      o_Release_Pulse <= 1'b0;
      o_Active        <= 1'b0;
    end else begin
      o_Event_Valid   <= 1'b0;
      o_Event_Repeat  <= 1'b0;
      o_Release_Pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (|i_Switch) begin
            o_Event_Valid <= 1'b1;
            o_Event_Key   <= first_key;
            o_Active      <= 1'b1;
            cnt           <= '0;
            state         <= REPEAT_ENABLE[first_key] ? HOLD_DELAY : HOLD_NOREP;
          end
        end

        HOLD_DELAY, HOLD_REPEAT, HOLD_NOREP: begin
          // Release is checked first so a coincident repeat is dropped.
          if (!key_held) begin
            o_Release_Pulse <= 1'b1;
            cnt             <= '0;
            state           <= WAIT_ALL;
          end else if (state == HOLD_DELAY) begin
            if (cnt == DELAY_LAST) begin
              o_Event_Valid  <= 1'b1;
              o_Event_Repeat <= 1'b1;
              cnt            <= '0;
              state          <= HOLD_REPEAT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (state == HOLD_REPEAT) begin
            if (cnt == PERIOD_LAST) begin
              o_Event_Valid  <= 1'b1;
              o_Event_Repeat <= 1'b1;
              cnt            <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        WAIT_ALL: begin
          if (i_Switch == '0) begin
            o_Active <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          o_Active <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_generator.sv
// Bench for key_event_generator: directed scenarios with literal expectations plus
// randomized key activity checked every cycle against an age-based behavioural model.
module tb_key_event_generator;

  localparam int              NK  = 4;
  localparam int              DLY = 8;
  localparam int              PER = 3;
  localparam logic [NK-1:0]   EN  = 4'b0111;

  logic          i_Clk = 1'b0;
  logic          i_Rst;
  logic [NK-1:0] i_Switch;
  logic          o_Event_Valid;
  logic [1:0]    o_Event_Key;
  logic          o_Event_Repeat;
  logic          o_Release_Pulse;
  logic          o_Active;

  int n_vec = 0;
  int n_err = 0;
  int edge_no = 0;

  key_event_generator #(
    .NUM_KEYS(NK), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .REPEAT_ENABLE(EN)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
    .o_Event_Valid(o_Event_Valid), .o_Event_Key(o_Event_Key),
    .o_Event_Repeat(o_Event_Repeat), .o_Release_Pulse(o_Release_Pulse),
    .o_Active(o_Active)
  );

  always #5 i_Clk = ~i_Clk;

  // Behavioural model: a tracked key with its age since the press, or a wait for all-up.
  bit tracking = 0, waiting = 0;
  int m_key = 0, age = 0;
  bit e_valid, e_rep, e_rel, e_act;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge i_Clk) begin
    logic [NK-1:0] sw;
    logic rst;
    sw = i_Switch;
    rst = i_Rst;
    e_valid = 0; e_rep = 0; e_rel = 0;
    if (rst) begin
      tracking = 0; waiting = 0; m_key = 0; age = 0;
    end else if (waiting) begin
      if (sw == 0) waiting = 0;
    end else if (tracking) begin
      age++;
      if (!sw[m_key]) begin
        e_rel = 1; tracking = 0; waiting = 1;
      end else if (EN[m_key] && age >= DLY && ((age - DLY) % PER) == 0) begin
        e_valid = 1; e_rep = 1;
      end
    end else if (sw != 0) begin
      for (int i = 0; i < NK; i++) begin
        if (sw[i]) begin m_key = i; break; end
      end
      e_valid = 1; e_rep = 0; tracking = 1; age = 0;
    end
    e_act = tracking || waiting;
    #1;
    chk("model_valid", o_Event_Valid, e_valid);
    chk("model_release", o_Release_Pulse, e_rel);
    chk("model_active", o_Active, e_act);
    if (e_valid || rst) chk("model_key", o_Event_Key, m_key);
    if (e_valid || rst) chk("model_repeat", o_Event_Repeat, e_rep);
  end

  task automatic step(input logic [NK-1:0] sw, input logic rst);
    @(negedge i_Clk);
    i_Switch = sw;
    i_Rst = rst;
    @(posedge i_Clk);
    #2;
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
  endtask

  int vcount;

  initial begin
    i_Rst = 1'b1;
    i_Switch = '0;
    step(4'b0000, 1'b1);
    chk("reset_valid", o_Event_Valid, 0);
    chk("reset_key", o_Event_Key, 0);
    chk("reset_active", o_Active, 0);
    chk("reset_release", o_Release_Pulse, 0);
    settle();

    // 1: key 2 (repeat enabled) held 5 edges, no repeat before release
    for (int e = 0; e <= 5; e++) begin
      step(e < 5 ? 4'b0100 : 4'b0000, 1'b0);
      chk("s1_valid", o_Event_Valid, e == 0);
      chk("s1_release", o_Release_Pulse, e == 5);
      if (e == 0) begin
        chk("s1_key", o_Event_Key, 2);
        chk("s1_rep", o_Event_Repeat, 0);
      end
    end
    settle();

    // 2: key 0 held 20 edges, repeats at 8,11,14,17; release at 20 drops the due repeat
    for (int e = 0; e <= 20; e++) begin
      step(e < 20 ? 4'b0001 : 4'b0000, 1'b0);
      chk("s2_valid", o_Event_Valid, (e == 0 || e == 8 || e == 11 || e == 14 || e == 17));
      chk("s2_release", o_Release_Pulse, e == 20);
      if (e == 8) chk("s2_rep", o_Event_Repeat, 1);
    end
    settle();

    // 3: keys 1 and 3 together, then key-3 ignored until all released
    for (int e = 0; e <= 10; e++) begin
      step(e < 4 ? 4'b1010 : (e < 7 ? 4'b1000 : (e < 10 ? 4'b0000 : 4'b1000)), 1'b0);
      chk("s3_valid", o_Event_Valid, (e == 0 || e == 10));
      chk("s3_release", o_Release_Pulse, e == 4);
      if (e == 0) chk("s3_key1", o_Event_Key, 1);
      if (e == 10) begin
        chk("s3_key3", o_Event_Key, 3);
        chk("s3_rep", o_Event_Repeat, 0);
      end
    end
    step(4'b0000, 1'b0);
    settle();

    // 4: reset pulse while key 0 in repeat phase
    for (int e = 0; e <= 22; e++) begin
      step(4'b0001, e == 12);
      if (e == 12) begin
        chk("s4_rst_valid", o_Event_Valid, 0);
        chk("s4_rst_active", o_Active, 0);
        chk("s4_rst_key", o_Event_Key, 0);
      end
      if (e >= 13) chk("s4_valid", o_Event_Valid, (e == 13 || e == 21));
      if (e == 13) chk("s4_press_rep", o_Event_Repeat, 0);
      if (e == 21) chk("s4_first_rep", o_Event_Repeat, 1);
    end
    step(4'b0000, 1'b0);
    settle();

    // 5: key 3 has repeat disabled
    vcount = 0;
    for (int e = 0; e < 40; e++) begin
      step(4'b1000, 1'b0);
      vcount += o_Event_Valid;
    end
    chk("s5_press_count", vcount, 1);
    step(4'b0000, 1'b0);
    chk("s5_release", o_Release_Pulse, 1);
    settle();

    // 6: single-edge press of key 1
    step(4'b0010, 1'b0);
    chk("s6_press", o_Event_Valid, 1);
    chk("s6_act0", o_Active, 1);
    step(4'b0000, 1'b0);
    chk("s6_release", o_Release_Pulse, 1);
    chk("s6_act1", o_Active, 1);
    step(4'b0000, 1'b0);
    chk("s6_idle", o_Active, 0);

    // Randomized key activity with occasional resets
    for (int seg = 0; seg < 250; seg++) begin
      logic [NK-1:0] pat;
      int len;
      pat = ($urandom_range(0, 3) == 0) ? 4'b0000 : NK'($urandom);
      len = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        step(pat, $urandom_range(0, 60) == 0);
      end
    end

    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
